gpio_seq_ctrl: RTL and testbench
================================

# gpio_seq_ctrl

Memory-mapped pattern sequencer and access arbiter placed between the CPU bus and the 8-bit GPIO output peripheral. Software loads up to eight (pattern, duration) steps, sets a prescaler and starts playback; the block then writes the GPIO peripheral autonomously on a timed schedule. While idle, CPU accesses to the GPIO pass through unchanged. While playing, the sequencer owns the GPIO write port.

## Interface
Parameters:
- PRESC_W, 16, prescaler width in bits (4..24)
- DUR_W, 8, per-step duration width in bits (1..16)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset: asynchronous, active-high
- sel_i  in  1  sequencer register select
- wen_i  in  1  write enable; read when 0
- addr_i  in  4  word index into the register map
- data_i  in  32  CPU write data
- data_o  out  32  register read data; 0 unless sel_i & !wen_i
- cpu_gpio_sel_i  in  1  CPU select for the GPIO peripheral
- cpu_gpio_wen_i  in  1  CPU write enable for the GPIO peripheral
- cpu_gpio_data_i  in  32  CPU write data for the GPIO peripheral
- cpu_gpio_data_o  out  32  GPIO read data returned to the CPU
- gpio_sel_o  out  1  select to the GPIO peripheral
- gpio_wen_o  out  1  write enable to the GPIO peripheral
- gpio_data_o  out  32  write data to the GPIO peripheral
- gpio_data_i  in  32  read data from the GPIO peripheral

## Operation
- Register map (word index):
  - 0x0 CTRL: write bit0 START, bit1 STOP, bit2 LOOP, bit3 = 1 clears BLOCKED. Read bit0 BUSY, bit2 LOOP, bit3 BLOCKED, bits[6:4] current step index.
  - 0x1 LEN: bits[2:0] = number of steps minus 1.
  - 0x2 PRESC: bits[PRESC_W-1:0] = P. One tick lasts P+1 cycles.
  - 0x8..0xF STEPk: bits[7:0] = pattern, bits[8+DUR_W-1:8] = D. Step k holds for D+1 ticks.
  - Reads of unmapped indices return 0. Writes to unmapped indices are ignored. Register readback is combinational.
- FSM states:
  - IDLE. START moves to LOAD with step index 0.
  - LOAD. Lasts exactly one cycle. Drives gpio_sel_o=1, gpio_wen_o=1, gpio_data_o={24'b0, STEPk[7:0]}. Clears the prescaler and the duration counter, then moves to HOLD.
  - HOLD. Lasts (D+1)*(P+1) cycles. D and P are sampled at LOAD.
  - At the end of HOLD:
    - If k < LEN: k increments and the FSM moves to LOAD.
    - Else if LOOP=1: k returns to 0 and the FSM moves to LOAD.
    - Else the FSM moves to IDLE.
- BUSY = (state != IDLE).
- Arbitration:
  - In IDLE, gpio_* outputs mirror the cpu_gpio_* inputs, and cpu_gpio_data_o = gpio_data_i.
  - When BUSY and not in LOAD:
    - CPU GPIO reads pass through.
    - CPU GPIO writes are dropped, gpio_sel_o=gpio_wen_o=0, and BLOCKED is set (sticky).
  - In LOAD:
    - The sequencer write wins.
    - cpu_gpio_data_o = 0.
    - A concurrent CPU GPIO write is dropped and sets BLOCKED.
- Boundary rules:
  - START while BUSY is ignored.
  - START and STOP in the same write: STOP wins, and the block stays in or returns to IDLE.
  - STOP in any state returns to IDLE on the next edge. A LOAD write already in progress in that cycle still completes. The GPIO keeps its last pattern.
  - LEN, PRESC and STEP writes while BUSY are accepted. They take effect at the next LOAD. LEN is compared live at the end of HOLD.
  - LOOP may be changed while BUSY. The end-of-sequence decision uses its current value.
  - A BLOCKED clear and a new blocked write in the same cycle: set wins.

## Timing
- Reset values:
  - state IDLE, all registers 0, k=0, BLOCKED=0.
  - gpio_sel_o, gpio_wen_o and gpio_data_o follow the cpu_gpio_* inputs (IDLE passthrough).
  - data_o = 0 when not selected.
- START latency: CTRL write sampled at edge t. BUSY=1 and LOAD are active in the cycle after edge t. The GPIO output updates at edge t+1.
- Step period = 1 + (D+1)*(P+1) cycles.
- Sequence duration without LOOP = sum over steps of that period. BUSY falls at the edge ending the last HOLD.
- Reset asserted mid-playback aborts immediately. GPIO contents are governed by the GPIO's own reset.

## Test plan
- P=0, LEN=0, STEP0={D=2, pattern 0xA5}, START: gpio write of 0x000000A5 in the cycle after the start; BUSY high for 4 cycles, then IDLE.
- LEN=2, P=1, patterns 0x01/0x02/0x04 with D=0: write edges spaced 3 cycles apart; returns to IDLE after the third HOLD; GPIO holds 0x04.
- LOOP=1 with two steps: after step 1 the next write is step 0's pattern. STOP mid-HOLD: no further gpio writes, BUSY=0 on the next edge.
- CPU GPIO write 0x3C while BUSY: the write is dropped and BLOCKED=1. Writing CTRL bit3=1 clears it. In IDLE the same write passes through and the GPIO reads back 0x3C.
- START+STOP in one write: BUSY stays 0 and no gpio write occurs. START while BUSY: step index is unaffected.
- Assert rst_i during HOLD: BUSY=0, all registers read 0, passthrough restored immediately.

Source files
------------

// File: rtl/gpio_seq_ctrl.sv
// GPIO pattern sequencer: plays up to eight timed (pattern, duration) steps into the GPIO
// write port and arbitrates CPU GPIO accesses against playback.
module gpio_seq_ctrl #(
  parameter int unsigned PRESC_W = 16,
  parameter int unsigned DUR_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sel_i,
  input  logic        wen_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        cpu_gpio_sel_i,
  input  logic        cpu_gpio_wen_i,
  input  logic [31:0] cpu_gpio_data_i,
  output logic [31:0] cpu_gpio_data_o,
  output logic        gpio_sel_o,
  output logic        gpio_wen_o,
  output logic [31:0] gpio_data_o,
  input  logic [31:0] gpio_data_i
);

  localparam int unsigned StepW = 8 + DUR_W;

  typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

  state_e             r_state, w_state_d;
  logic [2:0]         r_step, w_step_d;
  logic [2:0]         r_len;
  logic [PRESC_W-1:0] r_presc, r_p_lat, r_pcnt;
  logic [DUR_W-1:0]   r_d_lat, r_dcnt;
  logic               r_loop, r_blocked;
  logic [StepW-1:0]   r_steps [8];

  logic             w_wr, w_ctrl_wr, w_start, w_stop, w_busy, w_hold_done, w_blk_set;
  logic             w_unused_data;
  logic [StepW-1:0] w_cur_step;

  assign w_wr          = sel_i & wen_i;
  assign w_ctrl_wr     = w_wr & (addr_i == 4'h0);
  assign w_stop        = w_ctrl_wr & data_i[1];
  assign w_start       = w_ctrl_wr & data_i[0] & ~data_i[1];
  assign w_busy        = (r_state != StIdle);
  assign w_hold_done   = (r_pcnt == r_p_lat) & (r_dcnt == r_d_lat);
  assign w_cur_step    = r_steps[r_step];
  assign w_blk_set     = w_busy & cpu_gpio_sel_i & cpu_gpio_wen_i;
  assign w_unused_data = ^data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_step  <= '0;
    end else begin
      r_state <= w_state_d;
      r_step  <= w_step_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_step_d  = r_step;
    case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_d = StLoad;
          w_step_d  = '0;
        end
      end
      StLoad: w_state_d = StHold;
      StHold: begin
        // LEN and LOOP are sampled live so software can extend or end a running sequence.
        if (w_hold_done) begin
          if (r_step < r_len) begin
            w_step_d  = r_step + 3'd1;
            w_state_d = StLoad;
          end else if (r_loop) begin
            w_step_d  = '0;
            w_state_d = StLoad;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_stop) w_state_d = StIdle;
  end

  always_comb begin
    gpio_sel_o      = cpu_gpio_sel_i;
    gpio_wen_o      = cpu_gpio_wen_i;
    gpio_data_o     = cpu_gpio_data_i;
    cpu_gpio_data_o = gpio_data_i;
    case (r_state)
      StLoad: begin
        gpio_sel_o      = 1'b1;
        gpio_wen_o      = 1'b1;
        gpio_data_o     = {24'b0, w_cur_step[7:0]};
        cpu_gpio_data_o = '0;
      end
      StHold: begin
        gpio_sel_o = cpu_gpio_sel_i & ~cpu_gpio_wen_i;
        gpio_wen_o = 1'b0;
      end
      default: ;
    endcase
  end

  // Tick and duration counters; P and D are frozen at LOAD so mid-step writes wait a step.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pcnt  <= '0;
      r_dcnt  <= '0;
      r_p_lat <= '0;
      r_d_lat <= '0;
    end else if (r_state == StLoad) begin
      r_pcnt  <= '0;
      r_dcnt  <= '0;
      r_p_lat <= r_presc;
      r_d_lat <= w_cur_step[StepW-1:8];
    end else if (r_state == StHold && !w_hold_done) begin
      if (r_pcnt == r_p_lat) begin
        r_pcnt <= '0;
        r_dcnt <= r_dcnt + 1'b1;
      end else begin
        r_pcnt <= r_pcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_len   <= '0;
      r_presc <= '0;
      r_loop  <= 1'b0;
      for (int i = 0; i < 8; i++) r_steps[i] <= '0;
    end else if (w_wr) begin
      case (addr_i)
        4'h0: r_loop  <= data_i[2];
        4'h1: r_len   <= data_i[2:0];
        4'h2: r_presc <= data_i[PRESC_W-1:0];
        default: if (addr_i[3]) r_steps[addr_i[2:0]] <= data_i[StepW-1:0];
      endcase
    end
  end

  // A fresh blocked write beats a same-cycle clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_blocked <= 1'b0;
    end else if (w_blk_set) begin
      r_blocked <= 1'b1;
    end else if (w_ctrl_wr && data_i[3]) begin
      r_blocked <= 1'b0;
    end
  end

  always_comb begin
    data_o = '0;
    if (sel_i && !wen_i) begin
      case (addr_i)
        4'h0: data_o[6:0] = {r_step, r_blocked, r_loop, 1'b0, w_busy};
        4'h1: data_o[2:0] = r_len;
        4'h2: data_o[PRESC_W-1:0] = r_presc;
        default: if (addr_i[3]) data_o[StepW-1:0] = r_steps[addr_i[2:0]];
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// Scoreboard bench for gpio_seq_ctrl: a driver predicts GPIO writes and reads into queues,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_gpio_seq_ctrl;

  localparam int Big = 1 << 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0, wen = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic        cpu_sel = 1'b0, cpu_wen = 1'b0;
  logic [31:0] cpu_wdata = '0, cpu_rdata;
  logic        g_sel, g_wen;
  logic [31:0] g_wdata, g_rdata;
  logic [31:0] periph = '0;

  gpio_seq_ctrl #(.PRESC_W(16), .DUR_W(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sel_i          (sel),
    .wen_i          (wen),
    .addr_i         (addr),
    .data_i         (wdata),
    .data_o         (rdata),
    .cpu_gpio_sel_i (cpu_sel),
    .cpu_gpio_wen_i (cpu_wen),
    .cpu_gpio_data_i(cpu_wdata),
    .cpu_gpio_data_o(cpu_rdata),
    .gpio_sel_o     (g_sel),
    .gpio_wen_o     (g_wen),
    .gpio_data_o    (g_wdata),
    .gpio_data_i    (g_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Simple GPIO peripheral: a register written by gpio_* and read back on gpio_data_i.
  always @(posedge clk) if (g_sel && g_wen) periph <= g_wdata;
  assign g_rdata = periph;

  typedef struct { int cyc; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] exp; logic [31:0] mask; } rd_t;

  wr_t         wq[$];
  rd_t         rq[$];
  logic [31:0] cq[$];

  int  checks = 0, errors = 0;
  bit  done = 1'b0;
  wr_t m_w;
  rd_t m_r;
  logic [31:0] m_c;

  // Reference model of the programmed sequence.
  int m_len = 0, m_presc = 0, m_loop = 0;
  int m_dur[8];
  int m_pat[8];

  always @(negedge clk) begin
    if (wq.size() > 0 && wq[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL gpio_write_missing: got no write at cycle %0d, required %h", wq[0].cyc,
               wq[0].data);
      m_w = wq.pop_front();
    end
    if (g_sel && g_wen) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL gpio_write_unexpected: got %h at cycle %0d, required no write", g_wdata,
                 cyc);
      end else begin
        m_w = wq.pop_front();
        if (m_w.cyc != cyc || m_w.data != g_wdata) begin
          errors++;
          $display("FAIL gpio_write: got %h at cycle %0d, required %h at cycle %0d", g_wdata,
                   cyc, m_w.data, m_w.cyc);
        end
      end
    end
    if (sel && !wen) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL reg_read_unexpected: got %h, required no read", rdata);
      end else begin
        m_r = rq.pop_front();
        if ((rdata & m_r.mask) != m_r.exp) begin
          errors++;
          $display("FAIL reg_read addr %0d cycle %0d: got %h (mask %h), required %h", addr, cyc,
                   rdata, m_r.mask, m_r.exp);
        end
      end
    end else begin
      checks++;
      if (rdata != 32'h0) begin
        errors++;
        $display("FAIL data_o_unselected cycle %0d: got %h, required 0", cyc, rdata);
      end
    end
    if (cpu_sel && !cpu_wen) begin
      checks++;
      if (cq.size() == 0) begin
        errors++;
        $display("FAIL cpu_gpio_read_unexpected: got %h, required no read", cpu_rdata);
      end else begin
        m_c = cq.pop_front();
        if (cpu_rdata != m_c) begin
          errors++;
          $display("FAIL cpu_gpio_read cycle %0d: got %h, required %h", cyc, cpu_rdata, m_c);
        end
      end
    end
    if (cyc > 50000) begin
      errors++;
      $display("FAIL timeout: got cycle %0d, required end before 50000", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
    if (done) begin
      checks++;
      if (wq.size() + rq.size() + cq.size() != 0) begin
        errors++;
        $display("FAIL queues_drained: got %0d/%0d/%0d pending, required 0/0/0", wq.size(),
                 rq.size(), cq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  function automatic int ctrl(int busy, int loop, int blk, int step);
    return busy | (loop << 2) | (blk << 3) | (step << 4);
  endfunction

  // Predicted sequencer writes from start cycle n up to cycle last; returns the cycle BUSY
  // drops for a non-looping sequence.
  function automatic int plan(int n, int last);
    int t = n + 1;
    int k = 0;
    while (t <= last) begin
      wq.push_back('{t, 32'(m_pat[k])});
      t += 1 + (m_dur[k] + 1) * (m_presc + 1);
      if (k < m_len) k++;
      else if (m_loop != 0) k = 0;
      else break;
    end
    return t;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    sel = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
    cpu_sel = 1'b0; cpu_wen = 1'b0; cpu_wdata = '0;
  endtask

  task automatic wr(int a, int d);
    tick(); sel = 1'b1; wen = 1'b1; addr = 4'(a); wdata = 32'(d);
  endtask

  task automatic rd(int a, int exp, int mask);
    tick(); sel = 1'b1; addr = 4'(a);
    rq.push_back('{32'(exp), 32'(mask)});
  endtask

  task automatic cpu_wr(int d, bit pass);
    tick(); cpu_sel = 1'b1; cpu_wen = 1'b1; cpu_wdata = 32'(d);
    if (pass) wq.push_back('{cyc, 32'(d)});
  endtask

  task automatic cpu_rd(int exp);
    tick(); cpu_sel = 1'b1;
    cq.push_back(32'(exp));
  endtask

  task automatic both(int a, int d, int cd);
    tick(); sel = 1'b1; wen = 1'b1; addr = 4'(a); wdata = 32'(d);
    cpu_sel = 1'b1; cpu_wen = 1'b1; cpu_wdata = 32'(cd);
  endtask

  task automatic wait_to(int c);
    while (cyc < c - 1) tick();
  endtask

  task automatic set_step(int k, int d, int p);
    wr(8 + k, (d << 8) | p); m_dur[k] = d; m_pat[k] = p;
  endtask

  task automatic set_len(int l);
    wr(1, l); m_len = l;
  endtask

  task automatic set_presc(int p);
    wr(2, p); m_presc = p;
  endtask

  task automatic start(int bits, int span, output int n, output int e);
    wr(0, bits);
    m_loop = (bits >> 2) & 1;
    n = cyc;
    e = plan(n, (span < 0) ? Big : n + span);
  endtask

  initial begin
    int n, e, l;
    for (int i = 0; i < 8; i++) begin m_dur[i] = 0; m_pat[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, unmapped access, idle passthrough.
    rd(0, 0, -1); rd(1, 0, -1); rd(2, 0, -1); rd(8, 0, -1);
    wr(5, 'hFF); rd(5, 0, -1);
    cpu_wr('h3C, 1'b1); cpu_rd('h3C);

    // Single step, P=0, D=2: BUSY for 4 cycles.
    set_presc(0); set_len(0); set_step(0, 2, 'hA5);
    rd(8, 'h2A5, -1);
    start(1, -1, n, e);
    rd(0, ctrl(1, 0, 0, 0), -1);
    wait_to(e - 1); rd(0, ctrl(1, 0, 0, 0), -1); rd(0, ctrl(0, 0, 0, 0), 'h0F);
    cpu_rd('hA5);

    // Three steps, P=1, D=0; blocked CPU write during HOLD.
    set_presc(1); set_len(2); set_step(0, 0, 'h01); set_step(1, 0, 'h02); set_step(2, 0, 'h04);
    start(1, -1, n, e);
    cpu_rd(0);
    cpu_rd('h01);
    cpu_wr('h3C, 1'b0);
    wait_to(e - 1); rd(0, ctrl(1, 0, 1, 2), -1); rd(0, ctrl(0, 0, 1, 0), 'h0F);
    cpu_rd('h04);
    wr(0, 8); rd(0, 0, 'h0F);
    cpu_wr('h3C, 1'b1); cpu_rd('h3C); rd(0, 0, 'h0F);

    // Looping two-step sequence, clear/set race, START while busy, STOP mid-HOLD.
    set_presc(0); set_len(1); set_step(0, 1, 'h11); set_step(1, 2, 'h22);
    start(5, 13, n, e);
    wait_to(n + 6); both(0, 'hC, 'h77);
    rd(0, ctrl(1, 1, 1, 1), -1);
    wait_to(n + 9); wr(0, 5);
    rd(0, ctrl(1, 1, 1, 0), -1);
    wait_to(n + 13); wr(0, 2); m_loop = 0;
    rd(0, ctrl(0, 0, 1, 0), 'h0F);
    repeat (20) tick();
    wr(0, 8); rd(0, 0, 'h0F);

    // START and STOP together.
    wr(0, 3); rd(0, 0, 'h01);
    repeat (10) tick();

    // Randomized sequences.
    for (int r = 0; r < 6; r++) begin
      l = int'($urandom_range(0, 7));
      set_presc(int'($urandom_range(0, 3)));
      set_len(l);
      for (int k = 0; k <= l; k++) set_step(k, int'($urandom_range(0, 3)),
                                            int'($urandom_range(0, 255)));
      start(1, -1, n, e);
      wait_to(e - 1); rd(0, 1, 'h01); rd(0, 0, 'h01);
      cpu_rd(m_pat[l]);
    end

    // Reset during HOLD: immediate abort and passthrough.
    set_presc(3); set_len(0); set_step(0, 3, 'h99);
    start(1, 4, n, e);
    wait_to(n + 5);
    tick(); rst = 1'b1; cpu_sel = 1'b1; cpu_wen = 1'b1; cpu_wdata = 32'h5A;
    wq.push_back('{cyc, 32'h5A});
    rd(0, 0, -1); rd(1, 0, -1);
    tick(); rst = 1'b0;
    m_len = 0; m_presc = 0; m_loop = 0;
    rd(2, 0, -1); rd(8, 0, -1); rd(0, 0, -1);
    cpu_rd('h5A);
    repeat (5) tick();

    done = 1'b1;
    repeat (4) @(posedge clk);
  end

endmodule
